// File: rtl/vector_sweep_pkg.sv
// Shared types and default MISR constants for the vector-sweep BIST engine.
package vector_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        DONE
    } state_t;

    localparam logic [15:0] MISR_POLY_DEF = 16'hB400;
    localparam logic [15:0] MISR_SEED_DEF = 16'hFFFF;

endpackage

// File: rtl/vector_sweep_bist_misr_reg.sv
// Galois multiple-input signature register with seed load and capture enable.
module misr_reg
    import vector_sweep_pkg::*;
#(
    parameter int unsigned     W    = 16,
    parameter logic [W-1:0]    POLY = W'(MISR_POLY_DEF),
    parameter logic [W-1:0]    SEED = W'(MISR_SEED_DEF)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_seed,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] sig
);

    logic [W-1:0] sig_step;

    always_comb begin
        sig_step = {sig[W-2:0], 1'b0} ^ (sig[W-1] ? POLY : '0) ^ din;
    end

    // Seed load wins over capture so a restart always begins from a known value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= SEED;
        end else if (load_seed) begin
            sig <= SEED;
        end else if (en) begin
            sig <= sig_step;
        end
    end

endmodule

// File: rtl/vector_sweep_bist.sv
// Exhaustive-vector BIST: sweeps all input vectors, compacts DUT outputs into a MISR.
module vector_sweep_bist
    import vector_sweep_pkg::*;
#(
    parameter int unsigned          IN_W      = 4,
    parameter int unsigned          OUT_W     = 2,
    parameter int unsigned          DWELL     = 20,
    parameter int unsigned          MISR_W    = 16,
    parameter logic [MISR_W-1:0]    MISR_POLY = MISR_W'(MISR_POLY_DEF),
    parameter logic [MISR_W-1:0]    MISR_SEED = '1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [MISR_W-1:0] exp_sig,
    output logic [IN_W-1:0]   vec_out,
    output logic              vec_valid,
    input  logic [OUT_W-1:0]  dut_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [MISR_W-1:0] signature
);

    localparam int unsigned    DW_W    = $clog2(DWELL);
    localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL - 1);
    localparam logic [DW_W-1:0] DW_ONE  = DW_W'(1);
    localparam logic [IN_W:0]   VEC_ONE = (IN_W + 1)'(1);

    state_t            state;
    state_t            state_nxt;
    logic [IN_W:0]     vec_cnt;
    logic [IN_W:0]     vec_inc;
    logic [DW_W-1:0]   dwell;
    logic [MISR_W-1:0] din_ext;
    logic [MISR_W-1:0] sig_nxt;
    logic              last_dwell;
    logic              last_vec;
    logic              go;
    logic              capture;
    logic              finish;
    logic              clear;

    always_comb begin
        vec_inc    = vec_cnt + VEC_ONE;
        last_dwell = (dwell == DW_LAST);
        last_vec   = vec_inc[IN_W];
        din_ext    = MISR_W'(dut_out);
        // Same step as misr_reg; needed here so pass is judged on the value being captured.
        sig_nxt    = {signature[MISR_W-2:0], 1'b0} ^
                     (signature[MISR_W-1] ? MISR_POLY : '0) ^ din_ext;
    end

    always_comb begin
        state_nxt = state;
        go        = 1'b0;
        capture   = 1'b0;
        finish    = 1'b0;
        clear     = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    go        = 1'b1;
                    state_nxt = APPLY;
                end
            end
            APPLY: begin
                if (abort) begin
                    clear     = 1'b1;
                    state_nxt = IDLE;
                end else if (last_dwell) begin
                    capture = 1'b1;
                    if (last_vec) begin
                        finish    = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (abort) begin
                    clear     = 1'b1;
                    state_nxt = IDLE;
                end else if (start) begin
                    go        = 1'b1;
                    state_nxt = APPLY;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_cnt <= '0;
            dwell   <= '0;
            done    <= 1'b0;
            pass    <= 1'b0;
        end else if (clear || go) begin
            vec_cnt <= '0;
            dwell   <= '0;
            done    <= 1'b0;
            pass    <= 1'b0;
        end else if (state == APPLY) begin
            if (last_dwell) begin
                dwell <= '0;
                // On the final vector the counter is left at all-ones for the DONE phase.
                if (finish) begin
                    done <= 1'b1;
                    pass <= (sig_nxt == exp_sig);
                end else begin
                    vec_cnt <= vec_inc;
                end
            end else begin
                dwell <= dwell + DW_ONE;
            end
        end
    end

    misr_reg #(
        .W    (MISR_W),
        .POLY (MISR_POLY),
        .SEED (MISR_SEED)
    ) u_misr (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_seed (go),
        .en        (capture),
        .din       (din_ext),
        .sig       (signature)
    );

    assign vec_out   = vec_cnt[IN_W-1:0];
    assign vec_valid = (state == APPLY);
    assign busy      = (state == APPLY);

endmodule

// File: tb/tb_vector_sweep_bist.sv
// Randomized self-checking bench for vector_sweep_bist against a per-vector signature model.
module tb_vector_sweep_bist;

    localparam int DW   = 20;
    localparam int NVEC = 16;
    localparam int RUN  = NVEC * DW;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] exp_sig;
    logic [3:0]  vec_out;
    logic        vec_valid;
    logic [1:0]  dut_out;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] signature;
    logic [1:0]  truth [NVEC];

    logic        start6;
    logic        abort6;
    logic [15:0] exp_sig6;
    logic [0:0]  vec_out6;
    logic        vec_valid6;
    logic [0:0]  dut_out6;
    logic        busy6;
    logic        done6;
    logic        pass6;
    logic [15:0] signature6;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign dut_out  = truth[vec_out];
    assign dut_out6 = vec_out6;

    vector_sweep_bist #(
        .IN_W      (4),
        .OUT_W     (2),
        .DWELL     (DW),
        .MISR_W    (16),
        .MISR_POLY (16'hB400),
        .MISR_SEED (16'hFFFF)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .exp_sig   (exp_sig),
        .vec_out   (vec_out),
        .vec_valid (vec_valid),
        .dut_out   (dut_out),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .signature (signature)
    );

    vector_sweep_bist #(
        .IN_W      (1),
        .OUT_W     (1),
        .DWELL     (2),
        .MISR_W    (16),
        .MISR_POLY (16'hB400),
        .MISR_SEED (16'hFFFF)
    ) u_dut_small (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start6),
        .abort     (abort6),
        .exp_sig   (exp_sig6),
        .vec_out   (vec_out6),
        .vec_valid (vec_valid6),
        .dut_out   (dut_out6),
        .busy      (busy6),
        .done      (done6),
        .pass      (pass6),
        .signature (signature6)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] step(input logic [15:0] s, input logic [15:0] d);
        logic [15:0] fb;
        fb = (s >= 16'h8000) ? 16'hB400 : 16'h0000;
        return ((s * 2) & 16'hFFFF) ^ fb ^ d;
    endfunction

    // Signature after the first n vectors of the current truth table.
    function automatic logic [15:0] model_sig(input int n);
        logic [15:0] s;
        s = 16'hFFFF;
        for (int v = 0; v < n; v++) s = step(s, {14'b0, truth[v]});
        return s;
    endfunction

    function automatic void load_golden();
        for (int v = 0; v < NVEC; v++) begin
            logic a, b, c, d;
            a = ((v >> 3) & 1) != 0;
            b = ((v >> 2) & 1) != 0;
            c = ((v >> 1) & 1) != 0;
            d = (v & 1) != 0;
            truth[v] = {c | d, a & b};
        end
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_pass"}, 32'(pass), 0);
        check({tag, "_vec"}, 32'(vec_out), 0);
        check({tag, "_valid"}, 32'(vec_valid), 0);
    endtask

    // One run from a start pulse; optionally a lone start at poke_at and abort at abort_at.
    task automatic run_sweep(input int poke_at, input int abort_at, input bit start_too,
                             input bit exp_pass);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < RUN; k++) begin
            check("vec", 32'(vec_out), 32'(k / DW));
            check("valid", 32'(vec_valid), 1);
            check("done_early", 32'(done), 0);
            start = (k + 1 == poke_at) || (start_too && (k + 1 == abort_at));
            abort = (k + 1 == abort_at);
            tick();
            start = 1'b0;
            abort = 1'b0;
            if (k + 1 == abort_at) begin
                check_idle("abort");
                check("abort_sig", 32'(signature), 32'(model_sig((abort_at - 1) / DW)));
                return;
            end
        end
        check("end_done", 32'(done), 1);
        check("end_busy", 32'(busy), 0);
        check("end_valid", 32'(vec_valid), 0);
        check("end_vec", 32'(vec_out), 32'(NVEC - 1));
        check("end_sig", 32'(signature), 32'(model_sig(NVEC)));
        check("end_pass", 32'(pass), 32'(exp_pass));
    endtask

    initial begin
        logic [15:0] golden;
        logic [15:0] s6;
        bit          want;

        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        start6   = 1'b0;
        abort6   = 1'b0;
        exp_sig  = '0;
        exp_sig6 = '0;
        load_golden();

        #12;
        check_idle("rst");
        check("rst_sig", 32'(signature), 32'h0000FFFF);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Golden function sweep, then abort from DONE.
        exp_sig = model_sig(NVEC);
        run_sweep(-1, -1, 1'b0, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle("abort_done");
        check("abort_done_sig", 32'(signature), 32'(model_sig(NVEC)));

        // Single-bit fault on vector 1010.
        golden       = model_sig(NVEC);
        exp_sig      = golden;
        truth[10][0] = ~truth[10][0];
        run_sweep(-1, -1, 1'b0, 1'b0);
        check("fault_sig_ne", 32'(signature != golden), 1);
        load_golden();
        exp_sig = model_sig(NVEC);

        // Aborts mid-run: fixed, random, and after an ignored restart with start+abort.
        run_sweep(-1, 100, 1'b0, 1'b0);
        run_sweep(-1, int'($urandom_range(1, RUN - 1)), 1'b0, 1'b0);
        run_sweep(50, 150, 1'b1, 1'b0);

        // Random truth tables with matching or corrupted golden signatures.
        repeat (3) begin
            for (int v = 0; v < NVEC; v++) truth[v] = 2'($urandom);
            want    = 1'($urandom);
            exp_sig = model_sig(NVEC) ^ (want ? 16'h0 : 16'($urandom_range(1, 16'hFFFF)));
            run_sweep(-1, -1, 1'b0, want);
        end

        // Asynchronous reset in the middle of a run, then a clean full run.
        load_golden();
        exp_sig = model_sig(NVEC);
        start   = 1'b1;
        tick();
        start = 1'b0;
        repeat (150) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("mid_rst");
        check("mid_rst_sig", 32'(signature), 32'h0000FFFF);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        tick();
        check_idle("post_rst");
        run_sweep(-1, -1, 1'b0, 1'b1);

        // Minimal configuration: one input bit, two-clock dwell, output = input.
        s6       = step(step(16'hFFFF, 16'd0), 16'd1);
        exp_sig6 = s6;
        start6   = 1'b1;
        tick();
        start6 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("small_vec", 32'(vec_out6), 32'(k / 2));
            check("small_valid", 32'(vec_valid6), 1);
            check("small_done_early", 32'(done6), 0);
            tick();
        end
        check("small_done", 32'(done6), 1);
        check("small_sig", 32'(signature6), 32'(s6));
        check("small_pass", 32'(pass6), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
